disp_scan_ctrl: RTL

- Time-multiplexes NDIGITS common-cathode seven-segment digits.
- Holds one 4-bit value and one blank flag per digit in double-buffered registers.
- Presents the active digit's value on seg_num, which feeds the existing 4-bit-to-segment decoder, and drives the one-hot digit enables.
- Inserts a dark gap between digits to prevent ghosting. Applies new values only at frame boundaries so the display never tears.

---
 rtl/disp_scan_ctrl_if.sv | 23 ++
 rtl/disp_scan_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: write/commit bus and display outputs of the scan controller
interface disp_scan_ctrl_if #(
  parameter int NDIGITS = 4
);
  localparam int IW = $clog2(NDIGITS);
  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [3:0]         wr_data;
  logic               wr_blank;
  logic               commit;
  logic               commit_pending;
  logic [3:0]         seg_num;
  logic [NDIGITS-1:0] digit_en;
  logic               frame_start;
  modport master (
    output wr_en, wr_idx, wr_data, wr_blank, commit,
    input  commit_pending, seg_num, digit_en, frame_start
  );
  modport slave (
    input  wr_en, wr_idx, wr_data, wr_blank, commit,
    output commit_pending, seg_num, digit_en, frame_start
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: seven-segment scan with dark gaps and frame-synchronous commit; DISP_LZ_BLANK_EN adds leading-zero suppression
module disp_scan_ctrl #(
  parameter int NDIGITS = 4,
  parameter int DWELL   = 1000,
  parameter int GAP     = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  disp_scan_ctrl_if.slave bus
);
  localparam int IW   = $clog2(NDIGITS);
  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DW_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] GP_END = CW'(GAP - 1);
  localparam logic [IW-1:0] LAST   = IW'(NDIGITS - 1);
  typedef enum logic {S_GAP, S_ON} state_t;
  localparam state_t S_FIRST = (GAP == 0) ? S_ON : S_GAP;
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NDIGITS-1:0][4:0] shadow_q, shadow_d, active_q, active_d;
  logic                    pend_q, pend_d;
  logic [3:0]              seg_q, seg_d;
  logic [NDIGITS-1:0]      en_q, en_d;
  logic                    fs_q, fs_d;
  logic                    dwell_end, gap_end, boundary, on, lit;
`ifdef DISP_LZ_BLANK_EN
  logic                    zero_above;
`endif
  // all state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_FIRST;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      en_q     <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
    end
  end
  // scan sequencing, shadow writes and frame-boundary commit
  always_comb begin
    dwell_end = state_q == S_ON && cnt_q == DW_END;
    gap_end   = state_q == S_GAP && cnt_q == GP_END;
    boundary  = dwell_end && idx_q == LAST;
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    if (dwell_end) begin
      state_d = S_FIRST;
      cnt_d   = '0;
      idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end else if (gap_end) begin
      state_d = S_ON;
      cnt_d   = '0;
    end
    shadow_d = shadow_q;
    if (bus.wr_en && 32'(bus.wr_idx) < NDIGITS) shadow_d[bus.wr_idx] = {bus.wr_blank, bus.wr_data};
    active_d = (boundary && (pend_q || bus.commit)) ? shadow_d : active_q;
    pend_d   = !boundary && (pend_q || bus.commit);
  end
  // display drive decoded from the current scan position
  always_comb begin
    on  = state_q == S_ON;
    lit = on && !active_q[idx_q][4];
`ifdef DISP_LZ_BLANK_EN
    zero_above = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && active_q[i][3:0] == 4'd0;
      if (32'(idx_q) == i && zero_above) lit = 1'b0;
    end
`endif
    en_d  = lit ? NDIGITS'(1) << idx_q : '0;
    seg_d = on ? active_q[idx_q][3:0] : seg_q;
    fs_d  = on && idx_q == '0 && cnt_q == '0;
  end
  assign bus.commit_pending = pend_q;
  assign bus.seg_num        = seg_q;
  assign bus.digit_en       = en_q;
  assign bus.frame_start    = fs_q;
endmodule
